alu_op_executor: RTL and testbench

ALU_OP_EXECUTOR -- requirements
Module: alu_op_executor

---
 rtl/alu_op_executor.sv | 100 ++++++++++
 tb/tb_alu_op_executor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/alu_op_executor.sv
// Single-op ALU behind an IDLE/EXEC/DONE handshake. Results retire 1 edge after acceptance, or 8 edges for MUL.
// start is ignored while busy. A request held high is taken in the first IDLE cycle after DONE.
module alu_op_executor (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  address,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        op_done,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state;
  logic [2:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [2:0]  mul_cnt;
  logic [15:0] mul_acc;
  logic [15:0] mul_term;
  logic [15:0] alu_res;
  logic        alu_carry;

  always_comb begin
    alu_res   = 16'd0;
    alu_carry = 1'b0;
    // One partial product per EXEC cycle, LSB of b first.
    mul_term  = b_q[mul_cnt] ? ({8'd0, a_q} << mul_cnt) : 16'd0;
    case (op_q)
      3'd0: {alu_carry, alu_res[7:0]} = {1'b0, a_q} + {1'b0, b_q};
      3'd1: begin
        alu_res[7:0] = a_q - b_q;
        alu_carry    = (a_q < b_q);
      end
      3'd2: alu_res[7:0] = a_q & b_q;
      3'd3: alu_res[7:0] = a_q | b_q;
      3'd4: alu_res[7:0] = a_q ^ b_q;
      3'd5: alu_res[7:0] = a_q << b_q[2:0];
      3'd6: alu_res[7:0] = a_q >> b_q[2:0];
      default: alu_res = mul_acc + mul_term;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op_q    <= 3'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      mul_cnt <= 3'd0;
      mul_acc <= 16'd0;
      busy    <= 1'b0;
      op_done <= 1'b0;
      result  <= 16'd0;
      carry   <= 1'b0;
      zero    <= 1'b1;
    end else begin
      op_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= address;
            a_q     <= a;
            b_q     <= b;
            mul_cnt <= 3'd0;
            mul_acc <= 16'd0;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (op_q == 3'd7 && mul_cnt != 3'd7) begin
            mul_acc <= alu_res;
            mul_cnt <= mul_cnt + 3'd1;
          end else begin
            result  <= alu_res;
            carry   <= alu_carry;
            zero    <= (alu_res == 16'd0);
            op_done <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_executor.sv
// Randomized and directed checks of alu_op_executor against an arithmetic reference model.
module tb_alu_op_executor;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  address;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        op_done;
  logic [15:0] result;
  logic        carry;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  alu_op_executor dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .address (address),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .op_done (op_done),
    .result  (result),
    .carry   (carry),
    .zero    (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input int op, input int av, input int bv,
                                output logic [15:0] r, output logic c);
    int v;
    c = 1'b0;
    case (op)
      0: begin v = av + bv; c = (v > 255); v = v % 256; end
      1: begin v = (av - bv + 256) % 256; c = (av < bv); end
      2: v = av & bv;
      3: v = av | bv;
      4: v = av ^ bv;
      5: v = (av << (bv % 8)) % 256;
      6: v = av >> (bv % 8);
      default: v = av * bv;
    endcase
    r = v[15:0];
  endfunction

  task automatic run_op(input int op, input int av, input int bv, input bit noise);
    logic [15:0] er;
    logic        ec;
    int          n;
    bit          seen;
    bit          busy_ok;
    model(op, av, bv, er, ec);
    @(negedge clk);
    start = 1'b1; address = op[2:0]; a = av[7:0]; b = bv[7:0];
    @(negedge clk);
    start = 1'b0;
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < 20) begin
      if (op_done) seen = 1'b1;
      else begin
        n++;
        if (!busy) busy_ok = 1'b0;
        if (noise) begin
          start = 1'($urandom_range(0, 1)); address = 3'd0;
          a = 8'($urandom); b = 8'($urandom);
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk("op_done_seen", 32'(seen), 32'd1);
    chk("exec_cycles", 32'(n), (op == 7) ? 32'd8 : 32'd1);
    chk("busy_exec", 32'(busy_ok), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    chk("result", 32'(result), 32'(er));
    chk("zero", 32'(zero), 32'(er == 16'd0));
    if (op != 7) chk("carry", 32'(carry), 32'(ec));
    @(negedge clk);
    chk("op_done_single", 32'(op_done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("result_hold", 32'(result), 32'(er));
  endtask

  initial begin
    logic [15:0] er;
    logic        ec;
    bit          no_done;
    reset = 1'b0; start = 1'b0; address = 3'd0; a = 8'd0; b = 8'd0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_op_done", 32'(op_done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_carry", 32'(carry), 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset = 1'b1;

    run_op(0, 8'hF0, 8'h20, 1'b0);
    chk("add_lit", 32'({carry, zero, result}), 32'({1'b1, 1'b0, 16'h0010}));
    run_op(1, 8'h05, 8'h05, 1'b0);
    chk("sub_eq_lit", 32'({carry, zero, result}), 32'({1'b0, 1'b1, 16'h0000}));
    run_op(1, 8'h03, 8'h04, 1'b0);
    chk("sub_brw_lit", 32'({carry, result}), 32'({1'b1, 16'h00FF}));
    run_op(7, 8'hFF, 8'hFF, 1'b1);
    chk("mul_lit", 32'(result), 32'h0000FE01);
    run_op(5, 8'h81, 8'h03, 1'b0);
    chk("shl_lit", 32'(result), 32'h00000008);
    run_op(6, 8'h81, 8'h07, 1'b0);
    chk("shr_lit", 32'(result), 32'h00000001);

    // Back-to-back ADDs with start held: op_done every third cycle.
    model(0, 8'h7E, 8'h03, er, ec);
    @(negedge clk);
    start = 1'b1; address = 3'd0; a = 8'h7E; b = 8'h03;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk("b2b_op_done", 32'(op_done), (i % 3 == 2) ? 32'd1 : 32'd0);
      if (i % 3 == 2) chk("b2b_result", 32'(result), 32'(er));
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the 4th MUL cycle aborts silently.
    @(negedge clk);
    start = 1'b1; address = 3'd7; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_op_done", 32'(op_done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_carry", 32'(carry), 32'd0);
    chk("abort_zero", 32'(zero), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    no_done = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (op_done || busy) no_done = 1'b0;
    end
    chk("abort_quiet", 32'(no_done), 32'd1);
    run_op(0, 1, 1, 1'b0);
    chk("post_abort_add", 32'(result), 32'h00000002);

    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
